// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter that shares one N-bit mux4 datapath among four
// valid/ready requesters and registers the winning word into a
// single-entry output stage with its own valid/ready handshake.

// Two-way word selector: y = s ? b : a.
module mux2 #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         s,
    output logic [N-1:0] y
);
    assign y = s ? b : a;
endmodule

// Four-way word selector built as a tree of mux2 instances.
module mux4 #(
    parameter int N = 32
) (
    input  logic [N-1:0] d0,
    input  logic [N-1:0] d1,
    input  logic [N-1:0] d2,
    input  logic [N-1:0] d3,
    input  logic [1:0]   s,
    output logic [N-1:0] y
);
    logic [N-1:0] lo;
    logic [N-1:0] hi;

    mux2 #(.N(N)) u_lo  (.a(d0), .b(d1), .s(s[0]), .y(lo));
    mux2 #(.N(N)) u_hi  (.a(d2), .b(d3), .s(s[0]), .y(hi));
    mux2 #(.N(N)) u_top (.a(lo), .b(hi), .s(s[1]), .y(y));
endmodule

module mux4_rr_arbiter #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   in_valid,
    input  logic [N-1:0] in0,
    input  logic [N-1:0] in1,
    input  logic [N-1:0] in2,
    input  logic [N-1:0] in3,
    output logic [3:0]   in_ready,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic [1:0]   out_src,
    output logic [1:0]   sel
);
    // Priority pointer: the requester scanned first on the next arbitration.
    logic [1:0]   ptr;
    logic [1:0]   winner;
    logic [1:0]   cand;
    logic         found;
    logic         load;
    logic         grant;
    logic [N-1:0] mux_out;

    // The output stage can take a new word when empty or being drained.
    assign load  = !out_valid || out_ready;
    assign grant = load && found && !rst;

    // Scan requesters starting at ptr and pick the first one that is valid.
    always_comb begin
        winner = ptr;
        cand   = ptr;
        found  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cand = ptr + 2'(k);
            if (!found && in_valid[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    // One-hot acceptance toward the winning requester, zero when not loading.
    always_comb begin
        in_ready = 4'b0000;
        if (grant) begin
            in_ready[winner] = 1'b1;
        end
    end

    assign sel = winner;

    mux4 #(.N(N)) u_mux (
        .d0 (in0),
        .d1 (in1),
        .d2 (in2),
        .d3 (in3),
        .s  (sel),
        .y  (mux_out)
    );

    // ---- stage boundary: input arbitration -> registered output word ----
    // Load the granted word, drain to empty when idle, hold while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= 2'd0;
            ptr       <= 2'd0;
        end else if (load) begin
            if (found) begin
                out_data  <= mux_out;
                out_src   <= winner;
                out_valid <= 1'b1;
                ptr       <= winner + 2'd1;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: scenario tasks check grants
// inline and push expected output words into a scoreboard queue; an
// output-side process pops and compares words as the DUT presents them.
`timescale 1ns/1ps
module tb_mux4_rr_arbiter;
    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   in_valid;
    logic [N-1:0] in0, in1, in2, in3;
    logic [3:0]   in_ready;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;
    logic [1:0]   out_src;
    logic [1:0]   sel;

    int tests = 0;
    int fails = 0;

    // Expected output words: {src[1:0], data[N-1:0]}
    logic [N+1:0] sb[$];

    mux4_rr_arbiter #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in0       (in0),
        .in1       (in1),
        .in2       (in2),
        .in3       (in3),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src),
        .sel       (sel)
    );

    always #5 clk = ~clk;

    // Output side of the scoreboard: every valid word must match the queue front.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL sb_word: got src=%0d data=%h, expected no word", out_src, out_data);
            end else if ({out_src, out_data} !== sb[0]) begin
                fails++;
                $display("FAIL sb_word: got src=%0d data=%h, expected src=%0d data=%h",
                         out_src, out_data, sb[0][N+1:N], sb[0][N-1:0]);
            end
            if (out_ready && sb.size() != 0) void'(sb.pop_front());
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = 4'b0000;
        out_ready = 1'b1;
        next_cycle();
        next_cycle();
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        in0 = '0; in1 = '0; in2 = '0; in3 = '0;
        next_cycle();
        @(negedge clk);
        tests++;
        if (in_ready !== 4'b0000) begin
            fails++; $display("FAIL reset_in_ready: got %b, expected 0000", in_ready);
        end
        next_cycle();
        rst = 1'b0; in_valid = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++;
            if (out_valid !== 1'b0 || in_ready !== 4'b0000 || out_data !== '0) begin
                fails++;
                $display("FAIL reset_idle[%0d]: got valid=%b ready=%b data=%h, expected 0 0000 0",
                         i, out_valid, in_ready, out_data);
            end
            next_cycle();
        end
    endtask

    task automatic test_all_request();
        logic [3:0] exp_rdy;
        in0 = 32'hA0; in1 = 32'hA1; in2 = 32'hA2; in3 = 32'hA3;
        in_valid = 4'b1111; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            exp_rdy = 4'b0001 << (i % 4);
            tests++;
            if (in_ready !== exp_rdy || sel !== 2'(i % 4)) begin
                fails++;
                $display("FAIL all_req_grant[%0d]: got ready=%b sel=%0d, expected %b sel=%0d",
                         i, in_ready, sel, exp_rdy, i % 4);
            end
            if (i > 0) begin
                tests++;
                if (out_valid !== 1'b1) begin
                    fails++; $display("FAIL all_req_valid[%0d]: got %b, expected 1", i, out_valid);
                end
            end
            sb.push_back({2'(i % 4), 32'hA0 + 32'(i % 4)});
            next_cycle();
        end
        drain();
    endtask

    task automatic test_single_request();
        in2 = 32'h1234; in_valid = 4'b0100; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if (in_ready !== 4'b0100 || sel !== 2'd2) begin
                fails++;
                $display("FAIL single_grant[%0d]: got ready=%b sel=%0d, expected 0100 sel=2",
                         i, in_ready, sel);
            end
            sb.push_back({2'd2, 32'h1234});
            next_cycle();
        end
        drain();
    endtask

    task automatic test_stall();
        in1 = 32'h55; in_valid = 4'b0010; out_ready = 1'b1;
        @(negedge clk);
        tests++;
        if (in_ready !== 4'b0010) begin
            fails++; $display("FAIL stall_first: got %b, expected 0010", in_ready);
        end
        sb.push_back({2'd1, 32'h55});
        next_cycle();
        in0 = 32'h77; in3 = 32'h99; in_valid = 4'b1001; out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests++;
            if (in_ready !== 4'b0000 || out_valid !== 1'b1 || out_data !== 32'h55) begin
                fails++;
                $display("FAIL stall_hold[%0d]: got ready=%b valid=%b data=%h, expected 0000 1 55",
                         i, in_ready, out_valid, out_data);
            end
            next_cycle();
        end
        out_ready = 1'b1;
        @(negedge clk);
        tests++;
        if (in_ready !== 4'b1000 || sel !== 2'd3) begin
            fails++; $display("FAIL stall_release: got ready=%b sel=%0d, expected 1000 sel=3", in_ready, sel);
        end
        sb.push_back({2'd3, 32'h99});
        next_cycle();
        in_valid = 4'b0000;
        @(negedge clk);
        tests++;
        if (out_data !== 32'h99 || out_src !== 2'd3) begin
            fails++; $display("FAIL stall_next: got src=%0d data=%h, expected 3 99", out_src, out_data);
        end
        drain();
    endtask

    task automatic test_wrap();
        logic [3:0] exp_seq [3];
        exp_seq[0] = 4'b1000; exp_seq[1] = 4'b0001; exp_seq[2] = 4'b1000;
        // Grant requester 2 alone so the pointer lands on 3.
        in2 = 32'hC2; in_valid = 4'b0100; out_ready = 1'b1;
        @(negedge clk);
        tests++;
        if (in_ready !== 4'b0100) begin
            fails++; $display("FAIL wrap_setup: got %b, expected 0100", in_ready);
        end
        sb.push_back({2'd2, 32'hC2});
        next_cycle();
        in0 = 32'hC0; in3 = 32'hC3; in_valid = 4'b1001;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if (in_ready !== exp_seq[i]) begin
                fails++; $display("FAIL wrap_grant[%0d]: got %b, expected %b", i, in_ready, exp_seq[i]);
            end
            if (exp_seq[i] == 4'b1000) sb.push_back({2'd3, 32'hC3});
            else                       sb.push_back({2'd0, 32'hC0});
            next_cycle();
        end
        drain();
    endtask

    task automatic test_reset_mid_transfer();
        in2 = 32'hE2; in_valid = 4'b0100; out_ready = 1'b1;
        @(negedge clk);
        sb.push_back({2'd2, 32'hE2});
        next_cycle();
        in_valid = 4'b0000; out_ready = 1'b0;
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b1) begin
            fails++; $display("FAIL rst_mid_stall: got valid=%b, expected 1", out_valid);
        end
        next_cycle();
        rst = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        in0 = 32'hF0; in1 = 32'hF1; in2 = 32'hF2; in3 = 32'hF3;
        @(negedge clk);
        tests++;
        if (in_ready !== 4'b0000) begin
            fails++; $display("FAIL rst_mid_ready: got %b, expected 0000", in_ready);
        end
        sb.delete();
        next_cycle();
        rst = 1'b0; in_valid = 4'b0000;
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_src !== 2'd0) begin
            fails++;
            $display("FAIL rst_mid_clear: got valid=%b data=%h src=%0d, expected 0 0 0",
                     out_valid, out_data, out_src);
        end
        next_cycle();
        in_valid = 4'b1111;
        @(negedge clk);
        tests++;
        if (in_ready !== 4'b0001) begin
            fails++; $display("FAIL rst_mid_ptr: got %b, expected 0001", in_ready);
        end
        sb.push_back({2'd0, 32'hF0});
        next_cycle();
        drain();
    endtask

    initial begin
        test_reset();
        test_all_request();
        test_single_request();
        test_stall();
        test_wrap();
        test_reset_mid_transfer();
        @(negedge clk);
        tests++;
        if (sb.size() != 0) begin
            fails++; $display("FAIL sb_empty: got %0d words left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
